// File: rtl/score_keeper_ascii.sv
// Match score keeper: two saturating scores, shared double-dabble BCD engine,
// atomic ASCII digit update and winner detection for the score text ROM.
module score_keeper_ascii #(
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        my_point,
  input  logic        op_point,
  input  logic        game_restart,
  output logic [13:0] my_score_ASCII_1,
  output logic [13:0] my_score_ASCII_0,
  output logic [13:0] op_score_ASCII_1,
  output logic [13:0] op_score_ASCII_0,
  output logic [6:0]  number_of_player,
  output logic        game_over,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONV_MY = 2'd1;
  localparam logic [1:0] S_CONV_OP = 2'd2;
  localparam logic [1:0] S_UPDATE  = 2'd3;

  localparam logic [6:0] WIN       = 7'(WIN_SCORE);
  localparam logic [6:0] MAX_SCORE = 7'd99;
  localparam logic [6:0] ASCII_0   = 7'h30;

  logic [1:0] r_state;
  logic [6:0] r_my_score, r_op_score;
  logic [6:0] r_my_snap, r_op_snap;
  logic       r_lock, r_dirty;
  logic [6:0] r_bin;
  logic [7:0] r_bcd;
  logic [7:0] r_my_bcd;
  logic [2:0] r_cnt;
  logic [6:0] r_my_a1, r_my_a0, r_op_a1, r_op_a0;
  logic [6:0] r_np;
  logic       r_go;

  logic       w_my_inc, w_op_inc, w_any_inc;
  logic [6:0] w_my_next, w_op_next;
  logic [7:0] w_adj;
  logic [7:0] w_bcd_nx;
  logic [6:0] w_bin_nx;
  logic       w_my_win, w_op_win;

  always_comb begin
    w_my_inc  = my_point && !r_lock && (r_my_score != MAX_SCORE);
    w_op_inc  = op_point && !r_lock && (r_op_score != MAX_SCORE);
    w_any_inc = w_my_inc || w_op_inc;
    w_my_next = w_my_inc ? r_my_score + 7'd1 : r_my_score;
    w_op_next = w_op_inc ? r_op_score + 7'd1 : r_op_score;

    // One double-dabble step: add-3 correction per nibble, then shift {bcd, bin}
    w_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    w_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    w_bcd_nx   = {w_adj[6:0], r_bin[6]};
    w_bin_nx   = {r_bin[5:0], 1'b0};

    w_my_win = (r_my_snap >= WIN);
    w_op_win = (r_op_snap >= WIN);
  end

  always_ff @(posedge clk) begin
    if (rst || game_restart) begin
      r_state    <= S_IDLE;
      r_my_score <= '0;
      r_op_score <= '0;
      r_my_snap  <= '0;
      r_op_snap  <= '0;
      r_lock     <= 1'b0;
      r_dirty    <= 1'b0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_my_bcd   <= '0;
      r_cnt      <= '0;
      r_my_a1    <= ASCII_0;
      r_my_a0    <= ASCII_0;
      r_op_a1    <= ASCII_0;
      r_op_a0    <= ASCII_0;
      r_np       <= 7'h20;
      r_go       <= 1'b0;
    end else begin
      r_my_score <= w_my_next;
      r_op_score <= w_op_next;
      if ((w_my_next >= WIN) || (w_op_next >= WIN))
        r_lock <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_dirty) begin
            r_my_snap <= r_my_score;
            r_op_snap <= r_op_score;
            r_bin     <= r_my_score;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_dirty   <= 1'b0;
            r_state   <= S_CONV_MY;
          end
        end
        S_CONV_MY: begin
          r_bcd <= w_bcd_nx;
          r_bin <= w_bin_nx;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) begin
            r_my_bcd <= w_bcd_nx;
            r_bin    <= r_op_snap;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CONV_OP;
          end
        end
        S_CONV_OP: begin
          r_bcd <= w_bcd_nx;
          r_bin <= w_bin_nx;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) begin
            r_cnt   <= '0;
            r_state <= S_UPDATE;
          end
        end
        default: begin
          r_my_a1 <= {3'b011, r_my_bcd[7:4]};
          r_my_a0 <= {3'b011, r_my_bcd[3:0]};
          r_op_a1 <= {3'b011, r_bcd[7:4]};
          r_op_a0 <= {3'b011, r_bcd[3:0]};
          r_go    <= w_my_win || w_op_win;
          if (w_my_win && w_op_win)
            r_np <= 7'h30;
          else if (w_my_win)
            r_np <= 7'h31;
          else if (w_op_win)
            r_np <= 7'h32;
          else
            r_np <= 7'h20;
          r_state <= S_IDLE;
        end
      endcase

      // Points landing in the IDLE snapshot cycle must schedule another pass
      if (w_any_inc)
        r_dirty <= 1'b1;
    end
  end

  assign my_score_ASCII_1 = {7'b0, r_my_a1};
  assign my_score_ASCII_0 = {7'b0, r_my_a0};
  assign op_score_ASCII_1 = {7'b0, r_op_a1};
  assign op_score_ASCII_0 = {7'b0, r_op_a0};
  assign number_of_player = r_np;
  assign game_over        = r_go;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: doc/score_keeper_ascii.md
Name: score_keeper_ascii

Overview:
- Holds the match score for both players.
- Converts each score to two ASCII decimal digits with a shared iterative shift-add-3 (double-dabble) engine.
- Detects the winner.
- Sits directly upstream of the score text ROM and drives its digit and winner-number inputs: player-1 and player-2 tens/units ASCII, and the winner digit.

Parameters:
- WIN_SCORE, 10, score at which a player wins; legal range 1..99.

Ports:
- clk  input  1  system clock (pixel-domain clock of the text path)
- rst  input  1  synchronous, active-high reset
- my_point  input  1  one-cycle pulse: player 1 scored
- op_point  input  1  one-cycle pulse: player 2 scored
- game_restart  input  1  one-cycle pulse: clear match
- my_score_ASCII_1  output  14  player-1 tens digit, ASCII in [6:0], [13:7]=0
- my_score_ASCII_0  output  14  player-1 units digit, ASCII in [6:0], [13:7]=0
- op_score_ASCII_1  output  14  player-2 tens digit, same format
- op_score_ASCII_0  output  14  player-2 units digit, same format
- number_of_player  output  7  winner ASCII: 0x31 '1', 0x32 '2', 0x30 draw, 0x20 no winner
- game_over  output  1  match finished
- busy  output  1  conversion in progress (state != IDLE)

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on posedge clk.
  - rst is synchronous and active-high.
  - Reset values:
    - scores = 0
    - lock = 0, dirty = 0
    - state = IDLE
    - all four ASCII outputs = 0x0030
    - number_of_player = 0x20
    - game_over = 0
    - busy = 0
- Score registers:
  - Two 7-bit registers, my_score and op_score.
  - On an edge E0 with a point pulse and lock = 0, the affected score increments; both increment if both pulses are present.
  - Scores saturate at 99.
  - Any increment sets dirty.
  - If a score reaches WIN_SCORE at E0, lock is set at E0. While lock = 1, point pulses are ignored.
- Priority, highest first: rst > game_restart > point pulses.
- game_restart:
  - Forces the same values as reset, except that rst itself is not involved.
  - Aborts any conversion in progress.
  - Pulses arriving in the same cycle are dropped.
- FSM states: IDLE, CONV_MY, CONV_OP, UPDATE.
  - IDLE:
    - If dirty = 1, snapshot both scores, clear dirty, load the 7-bit shift register with my_score and the 8-bit BCD register with 0, then go to CONV_MY.
  - CONV_MY:
    - 7 iterations, one per cycle.
    - Each iteration: add 3 to any BCD nibble >= 5, then shift {bcd, bin} left by 1.
    - After the 7th iteration, store the player-1 BCD result, load the op snapshot, go to CONV_OP.
  - CONV_OP:
    - Same 7 iterations on the op snapshot.
    - Then go to UPDATE.
  - UPDATE:
    - Write all four ASCII outputs atomically: ASCII = {7'b0, 3'b011, nibble}.
    - Evaluate the winner from the snapshots and write number_of_player and game_over:
      - only my >= WIN_SCORE: 0x31
      - only op >= WIN_SCORE: 0x32
      - both >= WIN_SCORE: 0x30
    - Go to IDLE.
- Latency:
  - Pulse sampled at E0 gives new outputs visible after edge E0+16: 1 IDLE + 7 + 7 + 1 UPDATE.
  - Between E0 and E0+16 the outputs hold their previous values; they never show a partial mix.
- Points during a conversion:
  - Points arriving while busy update the scores and set dirty.
  - They are picked up by a second full pass that starts immediately after UPDATE returns to IDLE.
  - There is no loss and no restart of the current pass.
- Tens digit: leading '0' is emitted as 0x30, never blanked.

Test Plan:
1. Reset, then hold idle for 20 cycles -> all ASCII outputs 0x0030, number_of_player 0x20, game_over 0, busy 0.
2. Three my_point pulses spaced 30 cycles apart -> after the last, my digits 0x30/0x33, op digits 0x30/0x30; first change appears exactly 16 cycles after the pulse edge.
3. my_point and op_point in the same cycle, then op_point again 5 cycles later (while busy) -> first pass shows 01/01, second pass shows 01/02, busy deasserts after the second UPDATE.
4. WIN_SCORE=10; drive player 2 to 10 -> op digits 0x31/0x30, number_of_player 0x32, game_over 1; a further op_point leaves the score at 10.
5. Both players at 9, then simultaneous points -> 10/10, number_of_player 0x30, game_over 1.
6. game_restart asserted during CONV_OP together with my_point -> next cycle outputs 0x0030, game_over 0, number_of_player 0x20, busy 0, score stays 0.
